// File: rtl/rv_bus_pkg.sv
// Shared types for the RV32I memory bus arbiter.
// Arbiter state encoding and fault-cause codes.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    localparam logic FAULT_FETCH = 1'b0;
    localparam logic FAULT_DATA  = 1'b1;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for one bus transaction.
// Flags the last allowed BusReq cycle; tied off when MAX_WAIT is 0.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    if (MAX_WAIT == 0) begin : g_off
        logic unused_tie;
        assign unused_tie = ^{clk, rst, clr_i, en_i};
        assign expired_o  = 1'b0;
    end else begin : g_on
        localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
        logic [CW-1:0] cnt_q, cnt_d;

        // Clear at grant, count each cycle the slave is not ready
        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Counter register
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = (cnt_q == LAST);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Data has priority; each access waits for BusReady or times out.
module mem_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    InstrReqF,
    input  logic [ADDR_WIDTH-1:0]   PCF,
    input  logic                    FetchKill,
    output logic [DATA_WIDTH-1:0]   InstrF,
    output logic                    InstrValidF,
    output logic                    FetchStall,
    input  logic                    DataReqM,
    input  logic                    DataWeM,
    input  logic [ADDR_WIDTH-1:0]   DataAddrM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    input  logic [DATA_WIDTH/8-1:0] ByteEnM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    DataValidM,
    output logic                    MemStall,
    output logic                    BusReq,
    output logic                    BusWe,
    output logic [ADDR_WIDTH-1:0]   BusAddr,
    output logic [DATA_WIDTH-1:0]   BusWData,
    output logic [DATA_WIDTH/8-1:0] BusBe,
    input  logic [DATA_WIDTH-1:0]   BusRData,
    input  logic                    BusReady,
    output logic                    BusFault,
    output logic                    FaultCause
);

    localparam int BW = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0] be_q, be_d;
    logic we_q, we_d;
    logic killed_q, killed_d;
    logic cause_q, cause_d;

    logic in_idle, in_fetch, in_data, busy;
    logic grant, expired, timeout, done;
    logic kill_now, fetch_ok, data_done;

    assign in_idle  = (state_q == IDLE);
    assign in_fetch = (state_q == FETCH);
    assign in_data  = (state_q == DATA);
    assign busy     = in_fetch | in_data;
    assign grant    = in_idle & (DataReqM | InstrReqF);

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (grant),
        .en_i      (busy & ~BusReady),
        .expired_o (expired)
    );

    assign timeout   = busy & ~BusReady & expired;
    assign done      = busy & (BusReady | timeout);
    assign kill_now  = killed_q | (in_fetch & FetchKill);
    assign fetch_ok  = in_fetch & done & ~kill_now;
    assign data_done = in_data & done;

    assign BusReq      = busy;
    assign BusWe       = in_data & we_q;
    assign BusAddr     = addr_q;
    assign BusWData    = wdata_q;
    assign BusBe       = be_q;
    assign BusFault    = timeout;
    assign FaultCause  = cause_q;

    assign InstrValidF = fetch_ok;
    assign InstrF      = (fetch_ok & BusReady) ? BusRData : '0;
    assign DataValidM  = data_done;
    assign ReadDataM   = (data_done & BusReady & ~we_q) ? BusRData : '0;

    assign FetchStall  = InstrReqF & ~fetch_ok;
    assign MemStall    = DataReqM & ~data_done;

    // Grant, latch request fields, and return to IDLE on completion
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        killed_d = killed_q;
        cause_d  = cause_q;
        unique case (state_q)
            IDLE: begin
                if (DataReqM) begin
                    state_d = DATA;
                    addr_d  = DataAddrM;
                    wdata_d = WriteDataM;
                    be_d    = ByteEnM;
                    we_d    = DataWeM;
                end else if (InstrReqF) begin
                    state_d  = FETCH;
                    addr_d   = PCF;
                    wdata_d  = '0;
                    be_d     = '0;
                    we_d     = 1'b0;
                    killed_d = FetchKill;
                end
            end
            FETCH: begin
                if (FetchKill) begin
                    killed_d = 1'b1;
                end
                if (done) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                end
            end
            DATA: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout) begin
            cause_d = in_data ? FAULT_DATA : FAULT_FETCH;
        end
    end

    // Arbiter state and latched bus fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            killed_q <= 1'b0;
            cause_q  <= FAULT_FETCH;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            killed_q <= killed_d;
            cause_q  <= cause_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter.
// Stimulus queues expected completions; a monitor checks each pulse.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        InstrReqF, FetchKill;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        InstrValidF, FetchStall;
    logic        DataReqM, DataWeM;
    logic [31:0] DataAddrM, WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] ReadDataM;
    logic        DataValidM, MemStall;
    logic        BusReq, BusWe;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusBe;
    logic [31:0] BusRData;
    logic        BusReady, BusFault, FaultCause;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic [31:0] addr;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_WAIT   (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .InstrReqF   (InstrReqF),
        .PCF         (PCF),
        .FetchKill   (FetchKill),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .FetchStall  (FetchStall),
        .DataReqM    (DataReqM),
        .DataWeM     (DataWeM),
        .DataAddrM   (DataAddrM),
        .WriteDataM  (WriteDataM),
        .ByteEnM     (ByteEnM),
        .ReadDataM   (ReadDataM),
        .DataValidM  (DataValidM),
        .MemStall    (MemStall),
        .BusReq      (BusReq),
        .BusWe       (BusWe),
        .BusAddr     (BusAddr),
        .BusWData    (BusWData),
        .BusBe       (BusBe),
        .BusRData    (BusRData),
        .BusReady    (BusReady),
        .BusFault    (BusFault),
        .FaultCause  (FaultCause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic d, input logic [31:0] v,
                        input logic [31:0] a, input logic f);
        exp_t e;
        e.is_data = d;
        e.data    = v;
        e.addr    = a;
        e.fault   = f;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        InstrReqF  = 1'b0;
        FetchKill  = 1'b0;
        DataReqM   = 1'b0;
        DataWeM    = 1'b0;
        BusReady   = 1'b0;
        BusRData   = 32'h0;
    endtask

    // Scoreboard: every completion or fault pulse must match the queue head
    always @(negedge clk) begin
        if (rst && (InstrValidF || DataValidM || BusFault)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: iv=%b dv=%b flt=%b",
                         InstrValidF, DataValidM, BusFault);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_is_data", {31'h0, DataValidM}, {31'h0, e.is_data});
                chk("pulse_is_fetch", {31'h0, InstrValidF}, {31'h0, ~e.is_data});
                chk("pulse_data", e.is_data ? ReadDataM : InstrF, e.data);
                chk("pulse_addr", BusAddr, e.addr);
                chk("pulse_fault", {31'h0, BusFault}, {31'h0, e.fault});
                if (e.fault) begin
                    neg_cause_check(e.is_data);
                end
            end
        end
    end

    // FaultCause registers at the fault edge; check it just after
    task automatic neg_cause_check(input logic d);
        @(posedge clk);
        #1;
        chk("fault_cause", {31'h0, FaultCause}, {31'h0, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        PCF        = 32'h0;
        DataAddrM  = 32'h0;
        WriteDataM = 32'h0;
        ByteEnM    = 4'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        neg();
        chk("rst_busreq", {31'h0, BusReq}, 32'h0);
        chk("rst_buswe", {31'h0, BusWe}, 32'h0);
        chk("rst_busaddr", BusAddr, 32'h0);
        chk("rst_buswdata", BusWData, 32'h0);
        chk("rst_busbe", {28'h0, BusBe}, 32'h0);
        chk("rst_cause", {31'h0, FaultCause}, 32'h0);
        next();
        rst = 1'b1;

        // Zero-wait fetch
        InstrReqF = 1'b1;
        PCF       = 32'h100;
        push(1'b0, 32'h00500093, 32'h100, 1'b0);
        neg();
        chk("zf_c0_stall", {31'h0, FetchStall}, 32'h1);
        chk("zf_c0_busreq", {31'h0, BusReq}, 32'h0);
        next();
        BusReady = 1'b1;
        BusRData = 32'h00500093;
        neg();
        chk("zf_c1_busreq", {31'h0, BusReq}, 32'h1);
        chk("zf_c1_addr", BusAddr, 32'h100);
        chk("zf_c1_stall", {31'h0, FetchStall}, 32'h0);
        next();
        idle_inputs();
        neg();
        chk("zf_c2_busreq", {31'h0, BusReq}, 32'h0);
        next();

        // Contention: data wins, fetch follows
        InstrReqF = 1'b1;
        PCF       = 32'h104;
        DataReqM  = 1'b1;
        DataWeM   = 1'b0;
        DataAddrM = 32'h2000;
        push(1'b1, 32'h11223344, 32'h2000, 1'b0);
        push(1'b0, 32'h00a00113, 32'h104, 1'b0);
        neg();
        chk("ct_c0_memstall", {31'h0, MemStall}, 32'h1);
        chk("ct_c0_fstall", {31'h0, FetchStall}, 32'h1);
        next();
        BusReady = 1'b1;
        BusRData = 32'h11223344;
        neg();
        chk("ct_c1_addr", BusAddr, 32'h2000);
        chk("ct_c1_memstall", {31'h0, MemStall}, 32'h0);
        chk("ct_c1_buswe", {31'h0, BusWe}, 32'h0);
        next();
        DataReqM = 1'b0;
        BusReady = 1'b0;
        neg();
        chk("ct_c2_busreq", {31'h0, BusReq}, 32'h0);
        chk("ct_c2_fstall", {31'h0, FetchStall}, 32'h1);
        next();
        BusReady = 1'b1;
        BusRData = 32'h00a00113;
        neg();
        chk("ct_c3_addr", BusAddr, 32'h104);
        chk("ct_c3_busreq", {31'h0, BusReq}, 32'h1);
        next();
        idle_inputs();

        // Wait-state store
        DataReqM   = 1'b1;
        DataWeM    = 1'b1;
        DataAddrM  = 32'h2004;
        WriteDataM = 32'hDEADBEEF;
        ByteEnM    = 4'h3;
        push(1'b1, 32'h0, 32'h2004, 1'b0);
        neg();
        chk("st_c0_memstall", {31'h0, MemStall}, 32'h1);
        next();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                BusReady = 1'b1;
                BusRData = 32'hCAFEF00D;
            end
            neg();
            chk("st_buswe", {31'h0, BusWe}, 32'h1);
            chk("st_wdata", BusWData, 32'hDEADBEEF);
            chk("st_be", {28'h0, BusBe}, 32'h3);
            chk("st_memstall", {31'h0, MemStall}, {31'h0, k != 4});
            next();
        end
        idle_inputs();

        // Fetch timeout
        InstrReqF = 1'b1;
        PCF       = 32'h180;
        push(1'b0, 32'h0, 32'h180, 1'b1);
        next();
        for (int k = 1; k <= 15; k++) begin
            neg();
            chk("ft_busreq", {31'h0, BusReq}, 32'h1);
            chk("ft_fstall", {31'h0, FetchStall}, {31'h0, k != 15});
            next();
        end
        idle_inputs();
        neg();
        chk("ft_c16_busreq", {31'h0, BusReq}, 32'h0);
        next();

        // Data timeout
        DataReqM  = 1'b1;
        DataWeM   = 1'b0;
        DataAddrM = 32'h3000;
        push(1'b1, 32'h0, 32'h3000, 1'b1);
        next();
        for (int k = 1; k <= 15; k++) begin
            neg();
            chk("dt_busreq", {31'h0, BusReq}, 32'h1);
            chk("dt_memstall", {31'h0, MemStall}, {31'h0, k != 15});
            next();
        end
        idle_inputs();
        neg();
        chk("dt_c16_busreq", {31'h0, BusReq}, 32'h0);
        next();

        // Ready in the last allowed cycle beats the timeout
        DataReqM  = 1'b1;
        DataAddrM = 32'h3004;
        push(1'b1, 32'h55AA55AA, 32'h3004, 1'b0);
        next();
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) begin
                BusReady = 1'b1;
                BusRData = 32'h55AA55AA;
            end
            neg();
            chk("rw_busreq", {31'h0, BusReq}, 32'h1);
            next();
        end
        idle_inputs();
        neg();
        chk("rw_cause_held", {31'h0, FaultCause}, 32'h1);
        next();

        // Killed fetch runs to completion silently
        InstrReqF = 1'b1;
        PCF       = 32'h200;
        next();
        neg();
        chk("kl_c1_busreq", {31'h0, BusReq}, 32'h1);
        chk("kl_c1_addr", BusAddr, 32'h200);
        next();
        FetchKill = 1'b1;
        next();
        FetchKill = 1'b0;
        BusReady  = 1'b1;
        BusRData  = 32'h00000BAD;
        PCF       = 32'h300;
        push(1'b0, 32'h00000013, 32'h300, 1'b0);
        neg();
        chk("kl_c3_fstall", {31'h0, FetchStall}, 32'h1);
        chk("kl_c3_ivalid", {31'h0, InstrValidF}, 32'h0);
        next();
        BusReady = 1'b0;
        neg();
        chk("kl_c4_busreq", {31'h0, BusReq}, 32'h0);
        chk("kl_c4_fstall", {31'h0, FetchStall}, 32'h1);
        next();
        BusReady = 1'b1;
        BusRData = 32'h00000013;
        neg();
        chk("kl_c5_busreq", {31'h0, BusReq}, 32'h1);
        chk("kl_c5_addr", BusAddr, 32'h300);
        next();
        idle_inputs();

        // Reset during a waiting load
        DataReqM  = 1'b1;
        DataAddrM = 32'h4000;
        next();
        next();
        rst      = 1'b0;
        DataReqM = 1'b0;
        #1;
        chk("rs_busreq", {31'h0, BusReq}, 32'h0);
        chk("rs_busaddr", BusAddr, 32'h0);
        chk("rs_dvalid", {31'h0, DataValidM}, 32'h0);
        chk("rs_cause", {31'h0, FaultCause}, 32'h0);
        chk("rs_memstall", {31'h0, MemStall}, 32'h0);
        next();
        rst = 1'b1;

        InstrReqF = 1'b1;
        PCF       = 32'h100;
        push(1'b0, 32'h00500093, 32'h100, 1'b0);
        neg();
        chk("pr_c0_stall", {31'h0, FetchStall}, 32'h1);
        next();
        BusReady = 1'b1;
        BusRData = 32'h00500093;
        neg();
        chk("pr_c1_addr", BusAddr, 32'h100);
        chk("pr_c1_stall", {31'h0, FetchStall}, 32'h0);
        next();
        idle_inputs();
        repeat (3) next();

        chk("queue_empty", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
